// File: rtl/seven_segment_scanner_if.sv
// Display-value bus between the value producer and the seven-segment scanner,
// carrying the buffered load strobe and data plus the anode/decoder drive signals.
interface seven_segment_scanner_if;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  dp_mask_in;
  logic [3:0]  blank_in;
  logic        lz_en;
  logic [3:0]  AN;
  logic [3:0]  seg_data;
  logic        seg_dp;
  logic        pending;
  logic        frame_done;

  modport master (
    output load, digits_in, dp_mask_in, blank_in, lz_en,
    input  AN, seg_data, seg_dp, pending, frame_done
  );

  modport slave (
    input  load, digits_in, dp_mask_in, blank_in, lz_en,
    output AN, seg_data, seg_dp, pending, frame_done
  );
endinterface

// File: rtl/seven_segment_scanner.sv
// Four-digit seven-segment time-multiplexer with per-slot anti-ghost blanking,
// frame-synchronous double-buffered display values and leading-zero suppression.
module seven_segment_scanner #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2000
) (
  input  logic                   clk,
  input  logic                   reset,
  seven_segment_scanner_if.slave bus
);

  localparam int              CNT_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_C = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;

  logic [15:0] act_digits_q, act_digits_d;
  logic [3:0]  act_dp_q, act_dp_d;
  logic [3:0]  act_blank_q, act_blank_d;

  logic [15:0] pnd_digits_q, pnd_digits_d;
  logic [3:0]  pnd_dp_q, pnd_dp_d;
  logic [3:0]  pnd_blank_q, pnd_blank_d;
  logic        pnd_valid_q, pnd_valid_d;

  logic slot_end;
  logic boundary;
  logic in_blank;
  logic sup3, sup2, sup1;
  logic [3:0] suppressed;
  logic vis;
  logic lit;

  // Slot timing
  always_comb begin
    slot_end = (cnt_q == LAST_C);
    boundary = slot_end && (idx_q == 2'd3);
    cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
    idx_d    = slot_end ? idx_q + 2'd1 : idx_q;
  end

  generate
    if (BLANK_CYCLES == 0) begin : g_noblank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (cnt_q < BLANK_C);
    end
  endgenerate

  // A load landing on the boundary goes straight to the active set so it is not
  // delayed a whole frame; otherwise the pending set commits at the boundary.
  always_comb begin
    act_digits_d = act_digits_q;
    act_dp_d     = act_dp_q;
    act_blank_d  = act_blank_q;
    pnd_digits_d = pnd_digits_q;
    pnd_dp_d     = pnd_dp_q;
    pnd_blank_d  = pnd_blank_q;
    pnd_valid_d  = pnd_valid_q;
    if (bus.load) begin
      if (boundary) begin
        act_digits_d = bus.digits_in;
        act_dp_d     = bus.dp_mask_in;
        act_blank_d  = bus.blank_in;
        pnd_valid_d  = 1'b0;
      end else begin
        pnd_digits_d = bus.digits_in;
        pnd_dp_d     = bus.dp_mask_in;
        pnd_blank_d  = bus.blank_in;
        pnd_valid_d  = 1'b1;
      end
    end else if (boundary && pnd_valid_q) begin
      act_digits_d = pnd_digits_q;
      act_dp_d     = pnd_dp_q;
      act_blank_d  = pnd_blank_q;
      pnd_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      act_digits_q <= 16'h0000;
      act_dp_q     <= 4'b0000;
      act_blank_q  <= 4'b1111;
      pnd_digits_q <= 16'h0000;
      pnd_dp_q     <= 4'b0000;
      pnd_blank_q  <= 4'b0000;
      pnd_valid_q  <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      act_digits_q <= act_digits_d;
      act_dp_q     <= act_dp_d;
      act_blank_q  <= act_blank_d;
      pnd_digits_q <= pnd_digits_d;
      pnd_dp_q     <= pnd_dp_d;
      pnd_blank_q  <= pnd_blank_d;
      pnd_valid_q  <= pnd_valid_d;
    end
  end

  // Leading-zero chain from the most significant digit; digit 0 always shows.
  assign sup3       = bus.lz_en && (act_digits_q[15:12] == 4'h0);
  assign sup2       = sup3 && (act_digits_q[11:8] == 4'h0);
  assign sup1       = sup2 && (act_digits_q[7:4] == 4'h0);
  assign suppressed = {sup3, sup2, sup1, 1'b0};

  assign vis = ~act_blank_q[idx_q] & ~suppressed[idx_q];
  assign lit = vis & ~in_blank;

  assign bus.AN         = lit ? ~(4'b0001 << idx_q) : 4'b1111;
  assign bus.seg_data   = act_digits_q[{idx_q, 2'b00} +: 4];
  assign bus.seg_dp     = act_dp_q[idx_q] & lit;
  assign bus.pending    = pnd_valid_q;
  assign bus.frame_done = boundary;

endmodule

// File: doc/seven_segment_scanner.md
Name: seven_segment_scanner

Overview:
Time-multiplexing controller for the 4-digit Basys3 seven-segment display. It drives one shared seven_segment_decoder instance, cycling through the digits and asserting one anode at a time. Each digit slot starts with an anti-ghosting blank interval. New display values are double-buffered and committed only at frame boundaries, so a frame never shows a mix of old and new digits. It sits between top_level (value producer) and the decoder and anode pins.

Parameters:
REFRESH_DIV, 100000, clock cycles per digit slot (1 kHz per digit at 100 MHz); must be > BLANK_CYCLES.
BLANK_CYCLES, 2000, cycles at the start of each slot with all anodes off; 0 disables blanking.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
load  input  1  one-cycle strobe that captures digits_in, dp_mask_in and blank_in
digits_in  input  16  four BCD/hex nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3
dp_mask_in  input  4  per-digit decimal point, 1 = lit
blank_in  input  4  per-digit forced blank, 1 = dark
lz_en  input  1  leading-zero suppression enable (live, not buffered)
AN  output  4  anodes, active-low, AN[i] selects digit i
seg_data  output  4  nibble sent to the decoder's data input
seg_dp  output  1  sent to the decoder's dp_in (1 = DP lit)
pending  output  1  a loaded value is waiting for the next frame boundary
frame_done  output  1  one-cycle pulse at each frame boundary

Behaviour:
- Interface (already decided): one clock, clk. Reset is synchronous and active-high, named reset.
- State:
  - cnt counts 0..REFRESH_DIV-1.
  - idx is the 2-bit digit index.
  - Active registers: act_digits, act_dp, act_blank.
  - Pending registers: pnd_digits, pnd_dp, pnd_blank, and the flag pnd_valid.
- Reset values: cnt=0, idx=0, act_digits=0, act_dp=0, act_blank=4'b1111 (display dark), pnd_*=0, pnd_valid=0. Resulting outputs: AN=4'b1111, seg_data=0, seg_dp=0, pending=0, frame_done=0.
- Counter:
  - cnt increments every cycle.
  - At cnt=REFRESH_DIV-1, cnt goes to 0 and idx increments, wrapping from 3 to 0.
- Frame boundary: the cycle with idx=3 and cnt=REFRESH_DIV-1.
  - frame_done=1 in that cycle only, as a combinational decode of registered state.
- Commit: on the clock edge that ends a boundary cycle, if pnd_valid=1, act_* <= pnd_* and pnd_valid <= 0.
- Load:
  - When load=1, pnd_* capture the inputs and pnd_valid <= 1.
  - A load while pnd_valid=1 overwrites the pending value (latest wins).
  - A load in a boundary cycle bypasses pending: act_* take the input values directly, pnd_valid ends at 0, and the older pending value is discarded.
- pending = pnd_valid.
- Leading-zero suppression, computed from act_digits when lz_en=1: digit i (i = 3..1) is suppressed if it and every digit above it equal 0. Digit 0 is never suppressed. act_blank is applied independently of suppression.
- Outputs are combinational from registered state, with zero added latency:
  - vis = ~act_blank[idx] & ~suppressed[idx].
  - AN = 4'b1111 if cnt < BLANK_CYCLES or vis=0; otherwise AN has only bit idx low.
  - seg_data = act_digits[4*idx+:4] at all times.
  - seg_dp = act_dp[idx] & vis & (cnt >= BLANK_CYCLES).
- Reset asserted mid-frame: all state returns to reset values on the next edge, and any pending load is lost.
- Whether load is high in the reset cycle has no effect.

Test Plan:
1. REFRESH_DIV=8, BLANK_CYCLES=2. Reset, then load digits_in=16'h1234, dp_mask_in=0, blank_in=0.
   - AN stays 4'b1111 until the first frame_done, at cycle 31 after reset.
   - Then per slot: 2 cycles of 1111, then 6 cycles of 1110 (seg_data=4), then 1101 (3), then 1011 (2), then 0111 (1).
2. Load 16'hABCD in mid-frame.
   - pending=1 and the displayed digits stay 1234 until frame_done.
   - The next frame shows D, C, B, A, and pending=0.
3. Two loads in one frame (16'h1111, then 16'h2222).
   - The next frame shows only 2222.
4. Load 16'h5555 in the exact frame_done cycle.
   - The next frame shows 5555 and pending=0.
5. lz_en=1, digits 16'h0070.
   - AN[3] stays high for the whole frame; digits 1 and 0 are shown.
   - With 16'h0000, only digit 0 lights.
6. dp_mask_in=4'b0100, blank_in=4'b0001, then assert reset mid-frame.
   - seg_dp=1 only in slot 2 after the blank interval.
   - Digit 0's slot keeps AN=1111.
   - After reset, AN=1111 and pending=0 on the next cycle.
